// File: rtl/load_store_unit.sv
// Purpose: byte/half/word load-store front end for a word-wide data memory (optional MISALIGN_EXC_EN misalignment trap).
// Latency: loads and word stores respond 1 cycle after acceptance; byte/half stores respond 2 cycles after (read-modify-write).
// Backpressure: req_ready drops for the single MERGE cycle of a byte/half store; requester holds its request.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic                    resp_err_q, resp_err_d;
  // Byte/half store context held across the MERGE cycle
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic [1:0]              lane_q, lane_d;
  logic                    half_q, half_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   old_q, old_d;

  logic                    accept;
  logic                    sub_word;
  logic                    misaligned;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;

  assign accept   = req_valid && req_ready;
  assign sub_word = (req_size == 2'b00) || (req_size == 2'b01);

`ifdef MISALIGN_EXC_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                      (req_size == 2'b11);
`else
  // Unused low address bits are simply ignored; nothing traps.
  assign misaligned = 1'b0;
`endif

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Lane selection and sign/zero extension of the addressed load field
  always_comb begin
    byte_sel = mem_read_data[{req_addr[1:0], 3'b000} +: 8];
    half_sel = req_addr[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (req_size)
      2'b00:   load_ext = {{24{req_signed & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{req_signed & half_sel[15]}}, half_sel};
      default: load_ext = mem_read_data;
    endcase
  end

  // Old word with the stored byte or halfword spliced into its lane(s)
  always_comb begin
    merged = old_q;
    if (half_q) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only an aligned byte/half store enters MERGE, for one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && req_we && sub_word && !misaligned) state_d = MERGE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: memory port driven from the request in IDLE, from captured context in MERGE
  always_comb begin
    req_ready      = (state_q == IDLE) && !rst;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_addr       = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    mem_write_data = req_wdata;
    case (state_q)
      IDLE: begin
        if (req_valid && !rst && !misaligned) begin
          if (!req_we || sub_word) begin
            mem_read_en = 1'b1;
          end else begin
            mem_write_en = 1'b1;
          end
        end
      end
      MERGE: begin
        mem_addr       = {addr_q, 2'b00};
        mem_write_data = merged;
        mem_write_en   = !rst;
      end
      default: ;
    endcase
  end

  // Response and store-context next values
  always_comb begin
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    lane_d       = lane_q;
    half_d       = half_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    if (accept) begin
      if (misaligned) begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_rdata_d = '0;
      end else if (!req_we) begin
        resp_valid_d = 1'b1;
        resp_rdata_d = load_ext;
      end else if (sub_word) begin
        addr_d  = req_addr[ADDR_WIDTH-1:2];
        lane_d  = req_addr[1:0];
        half_d  = req_size[0];
        wdata_d = req_wdata[15:0];
        old_d   = mem_read_data;
      end else begin
        resp_valid_d = 1'b1;
      end
    end
    if (state_q == MERGE) begin
      resp_valid_d = 1'b1;
    end
  end

  // Response and store-context registers; reset discards any pending response
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      addr_q       <= '0;
      lane_q       <= '0;
      half_q       <= 1'b0;
      wdata_q      <= '0;
      old_q        <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      addr_q       <= addr_d;
      lane_q       <= lane_d;
      half_q       <= half_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: directed checks of load_store_unit against a word-wide memory model.
// Latency: expects 1-cycle responses for loads/word stores, 2 cycles for byte/half stores.
// Backpressure: holds requests until req_ready, bounded by cycle budgets.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:15];
  int tests = 0;
  int fails = 0;
  int pulses = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write lands on posedge
  assign mem_read_data = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[5:2]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (resp_valid) pulses = pulses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request, hold it until accepted, then wait for its response
  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    int n;
    rd = '0;
    er = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL issue_accept: req_ready got 0 after 20 cycles expected 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!resp_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      tests++; fails++;
      $display("FAIL issue_resp: resp_valid got 0 after 5 cycles expected 1");
      return;
    end
    rd = resp_rdata;
    er = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          p0;

  initial begin
    vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000};
    vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFFDE};
    vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'h000000AD};
    vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        32'hFFFFBEEF};
    vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000DEAD};
    vt[5]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'hFFFFFFEF};
    vt[6]  = '{1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'h000000BE};
    vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'h00007F80, 32'h000000BE};
    vt[8]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h00007F80};
    vt[9]  = '{1'b0, 2'b00, 1'b1, 32'h20, 32'h0,        32'hFFFFFF80};
    vt[10] = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vt[11] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        32'h00000000};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;

    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("t1_resp_rdata", resp_rdata, 32'd0);
    chk("t1_mem_write_en", {31'b0, mem_write_en}, 32'd0);
    chk("t1_req_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", {31'b0, req_ready}, 32'd1);

    // T2 table of loads and word stores
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d_err", i), {31'b0, er}, 32'd0);
    end

    // T3 byte store read-modify-write
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h55;
    chk("t3_ready_idle", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t3_ready_merge", {31'b0, req_ready}, 32'd0);
    chk("t3_write_en", {31'b0, mem_write_en}, 32'd1);
    chk("t3_write_data", mem_write_data, 32'hDEAD55EF);
    chk("t3_write_addr", mem_addr, 32'h10);
    chk("t3_no_early_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("t3_ready_back", {31'b0, req_ready}, 32'd1);
    chk("t3_resp", {31'b0, resp_valid}, 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    chk("t3_lw", rd, 32'hDEAD55EF);

    // T4 half store with a load held behind it
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    @(negedge clk);
    #1 p0 = pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h12; req_wdata = 32'h1234;
    @(posedge clk);
    #1 req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clk);
    chk("t4_ready_merge", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("t4_ready_back", {31'b0, req_ready}, 32'd1);
    chk("t4_sh_resp", {31'b0, resp_valid}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t4_lw_resp", {31'b0, resp_valid}, 32'd1);
    chk("t4_lw_rdata", resp_rdata, 32'h1234BEEF);
    repeat (3) @(negedge clk);
    chk("t4_pulses", pulses - p0, 32'd2);

    // T5 reset during MERGE abandons the store
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er);
    @(negedge clk);
    #1 p0 = pulses;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_write_en", {31'b0, mem_write_en}, 32'd0);
    chk("t5_read_en", {31'b0, mem_read_en}, 32'd0);
    chk("t5_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_pulses", pulses - p0, 32'd0);
    chk("t5_mem_word", mem[4], 32'hDEADBEEF);
    chk("t5_rdata_reset", resp_rdata, 32'd0);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er);
    chk("t5_lw", rd, 32'hDEADBEEF);

    // T6 misaligned word load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h11;
    #1;
`ifdef MISALIGN_EXC_EN
    chk("t6_read_en", {31'b0, mem_read_en}, 32'd0);
`else
    chk("t6_read_en", {31'b0, mem_read_en}, 32'd1);
`endif
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t6_resp", {31'b0, resp_valid}, 32'd1);
`ifdef MISALIGN_EXC_EN
    chk("t6_rdata", resp_rdata, 32'd0);
    chk("t6_err", {31'b0, resp_err}, 32'd1);
`else
    chk("t6_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t6_err", {31'b0, resp_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
